// File: rtl/div_pkg.sv
// div_pkg: op and FSM state encodings shared by divider_iter
package div_pkg;
    typedef enum logic [1:0] {OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11} op_e;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
endpackage

// File: rtl/divider_iter.sv
// divider_iter: fixed-latency restoring divider for DIV/DIVU/REM/REMU
module divider_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o,
    output logic             busy_o
);
    localparam int CW = $clog2(WIDTH);
    state_e           state;
    op_e              op;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo, dvs, rem, q_fix, r_fix;
    logic [WIDTH:0]   part, diff;
    logic             neg_q, neg_r, dz, a_neg, b_neg, fits;
    assign a_neg   = ~op_i[0] & dividend_i[WIDTH-1];
    assign b_neg   = ~op_i[0] & divisor_i[WIDTH-1];
    assign part    = {rem, quo[WIDTH-1]};
    assign diff    = part - {1'b0, dvs};
    assign fits    = ~diff[WIDTH];
    assign q_fix   = dz ? '1 : neg_q ? -quo : quo;
    assign r_fix   = neg_r ? -rem : rem;
    assign ready_o = state == IDLE;
    assign busy_o  = ~ready_o;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op       <= OP_DIV;
            cnt      <= '0;
            quo      <= '0;
            dvs      <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            result_o <= '0;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (valid_i) begin
                    state <= CALC;
                    op    <= op_e'(op_i);
                    cnt   <= '0;
                    quo   <= a_neg ? -dividend_i : dividend_i;
                    dvs   <= b_neg ? -divisor_i : divisor_i;
                    rem   <= '0;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    dz    <= divisor_i == '0;
                end
                CALC: begin
                    quo <= {quo[WIDTH-2:0], fits};
                    rem <= fits ? diff[WIDTH-1:0] : part[WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    result_o <= op inside {OP_REM, OP_REMU} ? r_fix : q_fix;
                    done_o   <= 1'b1;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_iter.sv
// tb_divider_iter: scoreboard bench for divider_iter against an arithmetic model
module tb_divider_iter;
    localparam int W = 32;
    typedef struct {
        logic [W-1:0] res;
        int           acc;
    } exp_t;
    logic         clk = 1'b0, reset = 1'b1, valid_i = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic [W-1:0] dividend_i = '0, divisor_i = '0;
    logic         ready_o, done_o, busy_o;
    logic [W-1:0] result_o;
    int           checks = 0, failures = 0;
    int           cyc = 0, n_acc = 0, done_cyc = -100;
    bit           chk_b2b = 1'b0;
    logic [W-1:0] last_res = '0;
    exp_t         sb[$];
    exp_t         pe, me;

    divider_iter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .result_o(result_o),
        .done_o(done_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa, sbv;
        sa  = a;
        sbv = b;
        if (b == '0) return op[1] ? a : '1;
        if (op[0]) return op[1] ? a % b : a / b;
        if (a == {1'b1, {(W-1){1'b0}}} && b == '1) return op[1] ? '0 : a;
        return op[1] ? sa % sbv : sa / sbv;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!reset && valid_i && ready_o) begin
            pe.res = model(op_i, dividend_i, divisor_i);
            pe.acc = cyc;
            sb.push_back(pe);
            n_acc++;
            if (chk_b2b) begin
                chk("b2b_accept_cycle", cyc, done_cyc + 2);
                chk_b2b = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy_not_ready", busy_o, !ready_o);
            if (done_o) begin
                chk("ready_in_done", ready_o, 1'b0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done_o=1 with result %h, expected no completion", result_o);
                end else begin
                    me = sb.pop_front();
                    chk("result", result_o, me.res);
                    chk("latency", cyc + 1 - me.acc, W + 2);
                    last_res = me.res;
                    done_cyc = cyc;
                end
            end else chk("result_hold", result_o, last_res);
        end
    end

    task automatic start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        @(negedge clk);
        while (!ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        valid_i = 1'b1;
        op_i = op;
        dividend_i = a;
        divisor_i = b;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_empty();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start(op, a, b);
        wait_empty();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int base, t;
        #1;
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_result", result_o, '0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        run(2'b01, 32'd100, 32'd7);              chk("divu_100_7", result_o, 32'd14);
        run(2'b11, 32'd100, 32'd7);              chk("remu_100_7", result_o, 32'd2);
        run(2'b00, 32'hFFFFFFF9, 32'd2);         chk("div_m7_2", result_o, 32'hFFFFFFFD);
        run(2'b10, 32'hFFFFFFF9, 32'd2);         chk("rem_m7_2", result_o, 32'hFFFFFFFF);
        run(2'b00, 32'd7, 32'hFFFFFFFE);         chk("div_7_m2", result_o, 32'hFFFFFFFD);
        run(2'b00, 32'h80000000, 32'hFFFFFFFF);  chk("div_ovf", result_o, 32'h80000000);
        run(2'b10, 32'h80000000, 32'hFFFFFFFF);  chk("rem_ovf", result_o, 32'h0);
        run(2'b01, 32'd5, 32'd0);                chk("divu_by0", result_o, 32'hFFFFFFFF);
        run(2'b10, 32'hFFFFFFF9, 32'd0);         chk("rem_by0", result_o, 32'hFFFFFFF9);
        run(2'b00, 32'hFFFFFFF9, 32'd0);         chk("div_neg_by0", result_o, 32'hFFFFFFFF);
        for (int i = 0; i < 60; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: begin a = 32'h80000000; b = '1; end
                3: b = -W'($urandom_range(1, 15));
                default: ;
            endcase
            run(op, a, b);
        end
        base = n_acc;
        t = 0;
        @(negedge clk);
        while (!ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        valid_i = 1'b1;
        op_i = 2'b01;
        dividend_i = 32'd1000;
        divisor_i = 32'd10;
        t = 0;
        while (n_acc == base && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk_b2b = 1'b1;
        repeat (5) @(negedge clk);
        dividend_i = 32'd77;
        divisor_i = 32'd5;
        repeat (10) @(negedge clk);
        op_i = 2'($urandom_range(0, 3));
        dividend_i = $urandom;
        divisor_i = $urandom;
        t = 0;
        while (n_acc < base + 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("held_accepts", n_acc - base, 2);
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        dividend_i = $urandom;
        divisor_i = $urandom;
        wait_empty();
        chk_b2b = 1'b0;
        run(2'b01, 32'd100, 32'd7);
        start(2'b01, 32'hFFFFFFFF, 32'd3);
        repeat (10) @(negedge clk);
        #2;
        sb.delete();
        reset = 1'b1;
        last_res = '0;
        #1;
        chk("midrst_ready", ready_o, 1'b1);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_done", done_o, 1'b0);
        chk("midrst_result", result_o, '0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (45) @(negedge clk);
        run(2'b01, 32'd9, 32'd3);                chk("divu_9_3", result_o, 32'd3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/divider_iter.md
DIVIDER_ITER -- requirements
Module: divider_iter

Interface
REQ-001 Parameters (name, default, meaning): WIDTH, 32, operand and result width in bits.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on rising edge.
- reset, in, 1, asynchronous, active-high reset.
- valid_i, in, 1, operation request.
- ready_o, out, 1, unit idle and able to accept.
- op_i, in, 2, 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i, in, WIDTH, rs1 operand.
- divisor_i, in, WIDTH, rs2 operand.
- result_o, out, WIDTH, quotient or remainder.
- done_o, out, 1, one-cycle completion pulse.
- busy_o, out, 1, operation in progress.

Function
REQ-003 The block SHALL implement the FSM states IDLE, CALC, FIX and DONE; it SHALL leave reset in IDLE.
REQ-004 ready_o SHALL be 1 only in IDLE, and busy_o SHALL equal NOT ready_o.
REQ-005 A request SHALL be accepted on a rising edge where valid_i=1 and the state is IDLE; operands and op_i SHALL be captured on that edge, and the FSM SHALL enter CALC.
REQ-006 While not in IDLE, valid_i and the operand inputs SHALL be ignored; no request is queued.
REQ-007 In signed ops (DIV, REM), operands SHALL be converted to magnitudes at capture, and the result signs SHALL be recorded.
REQ-008 CALC SHALL perform one restoring shift-subtract step per cycle for exactly WIDTH cycles.
- Step count held in a $clog2(WIDTH)-bit counter.
- Partial remainder WIDTH+1 bits wide.
REQ-009 After the final CALC step, the FSM SHALL enter FIX for one cycle.
REQ-010 In FIX, the block SHALL select the quotient or remainder per op_i.
- Quotient negated when signed and operand signs differ.
- Remainder negated when signed and the dividend was negative.
REQ-011 When the divisor is zero, the block SHALL produce quotient all ones (DIV and DIVU) and remainder equal to the original dividend (REM and REMU); this is applied in FIX.
REQ-012 For signed overflow (dividend = most negative, divisor = -1), the block SHALL produce DIV result = most negative and REM result = 0.
REQ-013 Latency SHALL be fixed for all operands, special cases included: done_o asserts in the cycle WIDTH+2 edges after the accept edge (34 for WIDTH=32).
REQ-014 In DONE, done_o SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-015 result_o SHALL be valid from DONE and SHALL hold until the next DONE; it SHALL not change during CALC or FIX.
REQ-016 A request presented in the DONE cycle SHALL not be accepted; the earliest new accept is the following IDLE cycle.
REQ-017 All arithmetic SHALL be modulo 2^WIDTH; negation is two's complement.

Reset
REQ-018 Asserting reset at any time, including mid-CALC, SHALL immediately force the following, and the aborted operation SHALL produce no done_o:
- state IDLE;
- ready_o=1, busy_o=0, done_o=0;
- result_o=0, step counter 0, internal operand registers 0.
REQ-019 The first accept after reset deassertion SHALL occur on the first rising edge at which reset=0 and valid_i=1.

Structure
REQ-020 A shared package div_pkg SHALL hold the op_i encoding enum and the FSM state enum, for reuse by the decoder and control unit.
REQ-021 The design SHALL be a single module with the step counter inline; a separate sub-module is not required.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (WIDTH=32):
- DIVU 100/7 -> result 14 with done_o 34 cycles after accept; REMU same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> 0xFFFFFFFD.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; latency still 34.
- DIVU 5/0 -> 0xFFFFFFFF; REM 0xFFFFFFF9/0 -> 0xFFFFFFF9.
- valid_i held high continuously -> the next accept occurs one cycle after DONE; operand changes mid-CALC do not alter result_o.
- reset pulsed at CALC step 10 -> ready_o=1, result_o=0, no done_o; a subsequent DIVU 9/3 -> 3.
